pipe_flow_ctrl: RTL and testbench
=================================

Name: pipe_flow_ctrl

Overview:
- Pipeline flow controller for the 5-stage RISC-V core.
- Consumes the EX-stage branch decision (pc_sel, halt) and ID/EX register indices.
- Sequences PC write-enable, IF/ID write-enable, and IF/ID and ID/EX flushes for taken transfers, load-use stalls and the halt drain.
- Sits beside the EX stage and drives the pipeline-register enables and the PC mux select.

Parameters:
- FLUSH_CYCLES, 1: bubble cycles inserted after a taken transfer, including the redirect cycle; legal range 1..4.
- DRAIN_CYCLES, 2: cycles allowed for MEM/WB to retire after halt is seen in EX, before HALTED; legal range 1..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction, not a bubble.
- ex_pc_sel  in  1  branch decision from EX: 1 means take branch_pc.
- ex_halt  in  1  halt instruction present in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- pc_write  out  1  PC register enable.
- pc_redirect  out  1  PC mux select: 1 means load branch_pc.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  clears IF/ID to a NOP.
- id_ex_flush  out  1  clears ID/EX to a NOP.
- halted  out  1  core fully stopped.

Behaviour:
- Registered state: enum {RUN, FLUSH, DRAIN, HALTED} plus counter cnt of width $clog2(5). Outputs are decoded combinationally from state and inputs.
- Reset: state=RUN, cnt=0. While reset=1, outputs are forced to: pc_write=0, pc_redirect=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, halted=0. Reset asserted mid-DRAIN or in HALTED returns to RUN on the next edge.
- Load-use hazard: lu = ex_valid & ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN, priority halt > transfer > load-use > normal:
  - ex_valid & ex_halt: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1. Next state DRAIN, cnt=DRAIN_CYCLES-1.
  - ex_valid & ex_pc_sel: pc_write=1, pc_redirect=1, if_id_flush=1, id_ex_flush=1. If FLUSH_CYCLES>1, next state FLUSH with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
  - lu: pc_write=0, if_id_write=0, id_ex_flush=1 (one bubble); stay in RUN. The stall lasts exactly 1 cycle, because the next cycle's EX is the bubble.
  - Otherwise: pc_write=1, if_id_write=1, no flushes.
- FLUSH: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, pc_redirect=0. When cnt==0, next state RUN; else cnt-1. An ex_pc_sel seen in FLUSH is ignored, since EX holds flushed NOPs. ex_valid & ex_halt is still honoured with the same action as in RUN.
- DRAIN: pc_write=0, if_id_write=0, both flushes=1. When cnt==0, next state HALTED; else cnt-1. All inputs are ignored.
- HALTED: same output values as DRAIN, plus halted=1. The only exit is reset.
- ex_pc_sel and ex_halt are qualified only by ex_valid. When ex_valid=0, no action is taken, regardless of the other inputs.

Optional Feature:
- Macro: PIPE_FLOW_STATS_EN.
- When defined, adds two outputs: redirect_cnt[31:0] and stall_cnt[31:0].
  - redirect_cnt increments on each cycle with pc_redirect=1.
  - stall_cnt increments on each load-use stall cycle.
  - Both reset to 0, wrap modulo 2^32, and hold their values in HALTED.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - flow_state_e enum (RUN, FLUSH, DRAIN, HALTED).
  - NO_CTRL/JAL/JALR/BRANCH 2-bit transfer-type constants, shared with the branch logic.
  - MAX_FLUSH and MAX_DRAIN constants (=4).
- One sub-module, hazard_detect: purely combinational load-use compare that produces lu. The FSM stays in pipe_flow_ctrl.

Test Plan:
- Reset held for 3 cycles, then released, with no hazards and ex_valid=0 → during reset, pc_write=0 and both flushes=1. Cycle 1 after release: pc_write=1, if_id_write=1, halted=0.
- ex_valid=1, ex_pc_sel=1 for one cycle, FLUSH_CYCLES=3 → pc_redirect=1 in that cycle, followed by exactly 2 FLUSH cycles with both flushes=1, then back to RUN. With the stats macro, redirect_cnt=1.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1, ex_valid=1 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1. Repeat the stimulus with ex_rd=0 → no stall.
- ex_valid=1 with ex_halt=1 and ex_pc_sel=1 in the same cycle, DRAIN_CYCLES=2 → halt wins and pc_redirect=0. halted=1 exactly 3 cycles later and stays high for 10+ cycles under random inputs.
- Reset pulsed during DRAIN with cnt=1 → the next cycle is RUN with halted=0, and normal fetch resumes.
- Stats macro defined: force redirect_cnt to 32'hFFFFFFFF, then take one branch → redirect_cnt wraps to 0.

Source files
------------

// File: rtl/pipe_flow_ctrl_pkg.sv
// rtl/pipe_flow_ctrl_pkg.sv - shared flow-controller state type and pipeline control constants
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } flow_state_e;

  // Transfer-type encoding shared with the branch unit
  localparam logic [1:0] NO_CTRL = 2'd0;
  localparam logic [1:0] JAL     = 2'd1;
  localparam logic [1:0] JALR    = 2'd2;
  localparam logic [1:0] BRANCH  = 2'd3;

  localparam int MAX_FLUSH = 4;
  localparam int MAX_DRAIN = 4;

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// rtl/pipe_flow_ctrl_if.sv - EX/ID hazard inputs and pipeline enables; stats ports under PIPE_FLOW_STATS_EN
interface pipe_flow_ctrl_if;
  logic       ex_valid;
  logic       ex_pc_sel;
  logic       ex_halt;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       pc_write;
  logic       pc_redirect;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       halted;
`ifdef PIPE_FLOW_STATS_EN
  logic [31:0] redirect_cnt;
  logic [31:0] stall_cnt;

  modport master (
    output ex_valid, ex_pc_sel, ex_halt, ex_mem_read, ex_rd,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_flush, halted,
           redirect_cnt, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_pc_sel, ex_halt, ex_mem_read, ex_rd,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_flush, halted,
           redirect_cnt, stall_cnt
  );
`else
  modport master (
    output ex_valid, ex_pc_sel, ex_halt, ex_mem_read, ex_rd,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_flush, halted
  );

  modport slave (
    input  ex_valid, ex_pc_sel, ex_halt, ex_mem_read, ex_rd,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_flush, halted
  );
`endif
endinterface

// File: rtl/pipe_flow_ctrl_hazard_detect.sv
// rtl/pipe_flow_ctrl_hazard_detect.sv - combinational load-use compare between EX load and ID sources
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is never a real dependency
  assign lu = ex_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - pipeline flow FSM (redirect flush, load-use stall, halt drain); PIPE_FLOW_STATS_EN adds counters
module pipe_flow_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  pipe_flow_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(5);
  localparam logic [CNT_W-1:0] FLUSH_INIT = (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

  flow_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic             halt_go;
  logic             xfer_go;

  logic pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_flush, halted;

  hazard_detect u_hazard_detect (
    .ex_valid    (bus.ex_valid),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .lu          (lu)
  );

  assign halt_go = bus.ex_valid && bus.ex_halt;
  assign xfer_go = bus.ex_valid && bus.ex_pc_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b0;
    pc_redirect = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;

    case (state_q)
      RUN: begin
        if (halt_go) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = DRAIN;
          cnt_d       = DRAIN_INIT;
        end else if (xfer_go) begin
          pc_write    = 1'b1;
          pc_redirect = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (lu) begin
          id_ex_flush = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      FLUSH: begin
        // EX only holds flushed NOPs here, so a stale pc_sel is ignored
        if (halt_go) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = DRAIN;
          cnt_d       = DRAIN_INIT;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      DRAIN: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (cnt_q == '0) state_d = HALTED;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      HALTED: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (reset) begin
      pc_write    = 1'b0;
      pc_redirect = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      halted      = 1'b0;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.pc_redirect = pc_redirect;
  assign bus.if_id_write = if_id_write;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.halted      = halted;

`ifdef PIPE_FLOW_STATS_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall;

  // A stall is only taken from RUN when nothing of higher priority fires
  assign stall = (state_q == RUN) && !reset && lu && !halt_go && !xfer_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (pc_redirect) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (stall)       stall_cnt_q    <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb/tb_pipe_flow_ctrl.sv - directed and random bench for pipe_flow_ctrl against a cycle model
module tb_pipe_flow_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int FL = 3;
  localparam int DR = 2;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_flow_ctrl_if bus ();

  pipe_flow_ctrl #(.FLUSH_CYCLES(FL), .DRAIN_CYCLES(DR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic ps, input logic h, input logic mr,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2);
    @(posedge clk);
    #1;
    reset           = r;
    bus.ex_valid    = v;
    bus.ex_pc_sel   = ps;
    bus.ex_halt     = h;
    bus.ex_mem_read = mr;
    bus.ex_rd       = rd;
    bus.id_rs1      = r1;
    bus.id_rs2      = r2;
    bus.id_use_rs1  = u1;
    bus.id_use_rs2  = u2;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  // Model: bubbles still owed after a redirect, drain cycles left, halted latch
  int          m_flush = 0;
  int          m_drain = 0;
  bit          m_halted = 0;
  logic [31:0] m_redirect = 0;
  logic [31:0] m_stall = 0;

  function automatic bit model_lu(input logic v, input logic mr, input logic [4:0] rd,
                                  input logic [4:0] r1, input logic [4:0] r2,
                                  input logic u1, input logic u2);
    if (!(v && mr) || rd == 5'd0) return 1'b0;
    return (u1 && r1 == rd) || (u2 && r2 == rd);
  endfunction

  // {pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_flush, halted}
  always @(negedge clk) begin
    logic [5:0] exp_v;
    logic [5:0] act_v;
    act_v = {bus.pc_write, bus.pc_redirect, bus.if_id_write,
             bus.if_id_flush, bus.id_ex_flush, bus.halted};
`ifdef PIPE_FLOW_STATS_EN
    check("redirect_cnt", bus.redirect_cnt, m_redirect);
    check("stall_cnt", bus.stall_cnt, m_stall);
`endif
    if (reset) begin
      exp_v = 6'b000110;
      m_flush = 0; m_drain = 0; m_halted = 0; m_redirect = 0; m_stall = 0;
    end else if (m_halted) begin
      exp_v = 6'b000111;
    end else if (m_drain > 0) begin
      exp_v = 6'b000110;
      m_drain--;
      if (m_drain == 0) m_halted = 1;
    end else if (bus.ex_valid && bus.ex_halt) begin
      exp_v = 6'b000110;
      m_drain = DR;
      m_flush = 0;
    end else if (m_flush > 0) begin
      exp_v = 6'b101110;
      m_flush--;
    end else if (bus.ex_valid && bus.ex_pc_sel) begin
      exp_v = 6'b110110;
      m_flush = FL - 1;
      m_redirect++;
    end else if (model_lu(bus.ex_valid, bus.ex_mem_read, bus.ex_rd, bus.id_rs1, bus.id_rs2,
                          bus.id_use_rs1, bus.id_use_rs2)) begin
      exp_v = 6'b000010;
      m_stall++;
    end else begin
      exp_v = 6'b101000;
    end
    check("flow_outputs", {26'd0, act_v}, {26'd0, exp_v});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.ex_valid = 0; bus.ex_pc_sel = 0; bus.ex_halt = 0; bus.ex_mem_read = 0;
    bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;

    // Reset held three cycles
    @(negedge clk);
    check("rst_pc_write", bus.pc_write, 0);
    check("rst_if_id_flush", bus.if_id_flush, 1);
    check("rst_id_ex_flush", bus.id_ex_flush, 1);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    check("run_pc_write", bus.pc_write, 1);
    check("run_if_id_write", bus.if_id_write, 1);
    check("run_halted", bus.halted, 0);

    // Unqualified halt/pc_sel must do nothing
    drive(0, 0, 1, 1, 1, 5'd3, 5'd3, 5'd3, 1, 1);
    check("noval_pc_write", bus.pc_write, 1);
    check("noval_redirect", bus.pc_redirect, 0);

    // Taken transfer: redirect then two flush cycles
    drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("xfer_redirect", bus.pc_redirect, 1);
    check("xfer_pc_write", bus.pc_write, 1);
    drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("flush1_redirect", bus.pc_redirect, 0);
    check("flush1_if_id", bus.if_id_flush, 1);
    idle();
    check("flush2_id_ex", bus.id_ex_flush, 1);
`ifdef PIPE_FLOW_STATS_EN
    check("stats_redirect_one", bus.redirect_cnt, 1);
`endif
    idle();
    check("back_run_flush", bus.if_id_flush, 0);

    // Load-use on rs2, then x0 and unused-source cases
    drive(0, 1, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
    check("lu_pc_write", bus.pc_write, 0);
    check("lu_if_id_write", bus.if_id_write, 0);
    check("lu_id_ex_flush", bus.id_ex_flush, 1);
    idle();
    check("lu_after_pc_write", bus.pc_write, 1);
    drive(0, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1);
    check("lu_x0_pc_write", bus.pc_write, 1);
    drive(0, 1, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0, 1);
    check("lu_unused_rs1", bus.pc_write, 1);
    drive(0, 1, 0, 0, 1, 5'd7, 5'd7, 5'd2, 1, 0);
    check("lu_rs1_stall", bus.pc_write, 0);

`ifdef PIPE_FLOW_STATS_EN
    idle();
    force dut.redirect_cnt_q = 32'hFFFF_FFFF;
    m_redirect = 32'hFFFF_FFFF;
    #1;
    release dut.redirect_cnt_q;
    drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    check("stats_redirect_wrap", bus.redirect_cnt, 0);
    idle();
    idle();
`endif

    // Halt beats a simultaneous transfer; halted three cycles later
    drive(0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("halt_redirect", bus.pc_redirect, 0);
    check("halt_pc_write", bus.pc_write, 0);
    idle();
    check("drain1_halted", bus.halted, 0);
    idle();
    check("drain2_halted", bus.halted, 0);
    idle();
    check("halted_set", bus.halted, 1);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      check("halted_hold", bus.halted, 1);
      check("halted_pc_write", bus.pc_write, 0);
    end
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    check("post_halt_run", bus.pc_write, 1);

    // Reset during DRAIN with cnt=1
    drive(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("drain_rst_pc_write", bus.pc_write, 0);
    idle();
    check("drain_rst_resume", bus.pc_write, 1);
    check("drain_rst_halted", bus.halted, 0);
    idle();
    check("drain_rst_halted2", bus.halted, 0);

    // Halt arriving during FLUSH is still honoured
    drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("flush_halt_pc_write", bus.pc_write, 0);
    idle();
    idle();
    idle();
    check("flush_halt_halted", bus.halted, 1);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

    // Random traffic, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 24) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, 1'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
